// File: rtl/countdown_ctrl.sv
// ============================================================================
// countdown_ctrl : button-driven 0-99 second countdown controller with BCD out
// Rev 1.0
// ============================================================================
`default_nettype none

module countdown_ctrl #(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int PRESET        = 99,
  parameter int DONE_HOLD_SEC = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_ss,
  input  logic       btn_clr,
  input  logic       preset_load,
  input  logic [6:0] preset_val,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       running,
  output logic       alarm,
  output logic       sec_tick
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int HW = (DONE_HOLD_SEC > 1) ? $clog2(DONE_HOLD_SEC + 1) : 1;

  localparam logic [PW-1:0] PRESC_MAX  = PW'(TICKS_PER_SEC - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'((DONE_HOLD_SEC > 0) ? DONE_HOLD_SEC - 1 : 0);
  localparam logic [6:0]    PRESET_SAT = 7'((PRESET > 99) ? 99 : PRESET);
  localparam logic [6:0]    COUNT_MAX  = 7'd99;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [6:0]      count_q, count_d;
  logic [6:0]      preset_q, preset_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic            sec_tick_q, sec_tick_d;
  logic            running_q, alarm_q;
  logic            btn_ss_q, btn_clr_q;

  logic            ss_e, clr_e;
  logic            presc_wrap;
  logic [PW-1:0]   presc_adv;
  logic [6:0]      preset_sat;
  logic [3:0]      tens_w;

  // ---------------------------------------------------------------------------
  // Button edges; the history flops reset high so a held button is not a press
  // ---------------------------------------------------------------------------
  assign ss_e  = btn_ss  & ~btn_ss_q;
  assign clr_e = btn_clr & ~btn_clr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_ss_q  <= 1'b1;
      btn_clr_q <= 1'b1;
    end else begin
      btn_ss_q  <= btn_ss;
      btn_clr_q <= btn_clr;
    end
  end

  assign presc_wrap = (presc_q == PRESC_MAX);
  assign presc_adv  = presc_wrap ? '0 : presc_q + PW'(1);
  assign preset_sat = (preset_val > COUNT_MAX) ? COUNT_MAX : preset_val;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      count_q    <= PRESET_SAT;
      preset_q   <= PRESET_SAT;
      presc_q    <= '0;
      hold_q     <= '0;
      sec_tick_q <= 1'b0;
      running_q  <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      preset_q   <= preset_d;
      presc_q    <= presc_d;
      hold_q     <= hold_d;
      sec_tick_q <= sec_tick_d;
      running_q  <= (state_d == S_RUN);
      alarm_q    <= (state_d == S_DONE);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic: clear beats start/stop, which beats load and the prescaler
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    preset_d   = preset_q;
    presc_d    = presc_q;
    hold_d     = hold_q;
    sec_tick_d = 1'b0;

    if (clr_e) begin
      state_d = S_IDLE;
      count_d = preset_q;
      presc_d = '0;
      hold_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ss_e) begin
            presc_d = '0;
            hold_d  = '0;
            state_d = (count_q == 7'd0) ? S_DONE : S_RUN;
          end else if (preset_load) begin
            preset_d = preset_sat;
            count_d  = preset_sat;
          end
        end

        S_RUN: begin
          if (ss_e) begin
            state_d = S_PAUSE;
          end else begin
            presc_d = presc_adv;
            if (presc_wrap) begin
              sec_tick_d = 1'b1;
              if (count_q <= 7'd1) begin
                count_d = 7'd0;
                state_d = S_DONE;
                hold_d  = '0;
              end else begin
                count_d = count_q - 7'd1;
              end
            end
          end
        end

        S_PAUSE: begin
          if (ss_e) begin
            state_d = S_RUN;
          end
        end

        S_DONE: begin
          count_d = 7'd0;
          if (ss_e) begin
            state_d = S_IDLE;
            count_d = preset_q;
            presc_d = '0;
            hold_d  = '0;
          end else begin
            presc_d = presc_adv;
            if (presc_wrap) begin
              sec_tick_d = 1'b1;
              if (hold_q >= HOLD_LAST) begin
                state_d = S_IDLE;
                count_d = preset_q;
                hold_d  = '0;
              end else begin
                hold_d = hold_q + HW'(1);
              end
            end
          end
        end

        default: begin
          state_d = S_IDLE;
          count_d = preset_q;
          presc_d = '0;
          hold_d  = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Binary to two BCD digits, straight from the count register
  // ---------------------------------------------------------------------------
  always_comb begin
    tens_w = 4'd0;
    for (int i = 1; i < 10; i++) begin
      if (count_q >= 7'(i * 10)) begin
        tens_w = 4'(i);
      end
    end
  end

  assign tens     = tens_w;
  assign ones     = 4'(count_q - (7'(tens_w) * 7'd10));
  assign running  = running_q;
  assign alarm    = alarm_q;
  assign sec_tick = sec_tick_q;

endmodule

`default_nettype wire

// File: tb/tb_countdown_ctrl.sv
// ============================================================================
// tb_countdown_ctrl : directed scoreboard bench for countdown_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_countdown_ctrl;

  logic       clk;
  logic       rst;
  logic       btn_ss;
  logic       btn_clr;
  logic       preset_load;
  logic [6:0] preset_val;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       running;
  logic       alarm;
  logic       sec_tick;

  countdown_ctrl #(
    .TICKS_PER_SEC (4),
    .PRESET        (99),
    .DONE_HOLD_SEC (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_ss      (btn_ss),
    .btn_clr     (btn_clr),
    .preset_load (preset_load),
    .preset_val  (preset_val),
    .tens        (tens),
    .ones        (ones),
    .running     (running),
    .alarm       (alarm),
    .sec_tick    (sec_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: after the Nth rising edge cyc==N
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    string      name;
    logic [3:0] t;
    logic [3:0] o;
    logic       r;
    logic       a;
    logic       k;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic expect_st(input int d, input string nm, input logic [3:0] t, input logic [3:0] o,
                           input logic r, input logic a, input logic k);
    exp_t e;
    e.at = cyc + d; e.name = nm; e.t = t; e.o = o; e.r = r; e.a = a; e.k = k;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are presented every cycle; compare on the falling edge
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      n_vec++;
      if (e.at < cyc) begin
        n_miss++;
        $display("FAIL %s: check missed (due cyc %0d, now %0d)", e.name, e.at, cyc);
      end else if ({tens, ones, running, alarm, sec_tick} !== {e.t, e.o, e.r, e.a, e.k}) begin
        n_miss++;
        $display("FAIL %s @cyc %0d: got t/o=%0d/%0d run=%b alarm=%b tick=%b, want t/o=%0d/%0d run=%b alarm=%b tick=%b",
                 e.name, cyc, tens, ones, running, alarm, sec_tick, e.t, e.o, e.r, e.a, e.k);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d miscompares=%0d", n_vec, n_miss);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; btn_ss = 1'b0; btn_clr = 1'b0; preset_load = 1'b0; preset_val = 7'd0;
    step(2);
    expect_st(0, "reset_state", 4'd9, 4'd9, 1'b0, 1'b0, 1'b0);
    step(1);
    rst = 1'b1;
    step(1);

    // 1: start from 99, first decrement four cycles after the start edge
    expect_st(0, "t1_idle_pre", 4'd9, 4'd9, 1'b0, 1'b0, 1'b0);
    btn_ss = 1'b1; step(1); btn_ss = 1'b0;
    expect_st(0, "t1_running",  4'd9, 4'd9, 1'b1, 1'b0, 1'b0);
    expect_st(3, "t1_pre_tick", 4'd9, 4'd9, 1'b1, 1'b0, 1'b0);
    expect_st(4, "t1_tick_98",  4'd9, 4'd8, 1'b1, 1'b0, 1'b1);
    expect_st(5, "t1_post_tick",4'd9, 4'd8, 1'b1, 1'b0, 1'b0);
    step(5);
    btn_clr = 1'b1; step(1); btn_clr = 1'b0;
    expect_st(0, "t1_clear",    4'd9, 4'd9, 1'b0, 1'b0, 1'b0);

    // 2: preset 5, count to zero, alarm held two seconds then reload
    preset_load = 1'b1; preset_val = 7'd5; step(1); preset_load = 1'b0;
    expect_st(0, "t2_load5",    4'd0, 4'd5, 1'b0, 1'b0, 1'b0);
    btn_ss = 1'b1; step(1); btn_ss = 1'b0;
    expect_st(0,  "t2_run",       4'd0, 4'd5, 1'b1, 1'b0, 1'b0);
    expect_st(19, "t2_count1",    4'd0, 4'd1, 1'b1, 1'b0, 1'b0);
    expect_st(20, "t2_done",      4'd0, 4'd0, 1'b0, 1'b1, 1'b1);
    expect_st(24, "t2_hold_tick", 4'd0, 4'd0, 1'b0, 1'b1, 1'b1);
    expect_st(27, "t2_hold_end",  4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    expect_st(28, "t2_reload",    4'd0, 4'd5, 1'b0, 1'b0, 1'b1);
    expect_st(29, "t2_idle",      4'd0, 4'd5, 1'b0, 1'b0, 1'b0);
    step(29);

    // 3: pause after two prescaler counts, resume keeps the partial second
    preset_load = 1'b1; preset_val = 7'd99; step(1); preset_load = 1'b0;
    expect_st(0, "t3_load99",   4'd9, 4'd9, 1'b0, 1'b0, 1'b0);
    btn_ss = 1'b1; step(1); btn_ss = 1'b0;
    expect_st(0, "t3_run",      4'd9, 4'd9, 1'b1, 1'b0, 1'b0);
    step(2);
    btn_ss = 1'b1; step(1); btn_ss = 1'b0;
    expect_st(0,  "t3_paused",   4'd9, 4'd9, 1'b0, 1'b0, 1'b0);
    expect_st(5,  "t3_frozen5",  4'd9, 4'd9, 1'b0, 1'b0, 1'b0);
    expect_st(10, "t3_frozen10", 4'd9, 4'd9, 1'b0, 1'b0, 1'b0);
    step(10);
    btn_ss = 1'b1; step(1); btn_ss = 1'b0;
    expect_st(0, "t3_resume",   4'd9, 4'd9, 1'b1, 1'b0, 1'b0);
    expect_st(1, "t3_resume1",  4'd9, 4'd9, 1'b1, 1'b0, 1'b0);
    expect_st(2, "t3_dec98",    4'd9, 4'd8, 1'b1, 1'b0, 1'b1);
    step(2);

    // 4: clear and start/stop in the same cycle at 97
    expect_st(4, "t4_at97",     4'd9, 4'd7, 1'b1, 1'b0, 1'b1);
    step(4);
    btn_clr = 1'b1; btn_ss = 1'b1; step(1); btn_clr = 1'b0; btn_ss = 1'b0;
    expect_st(0, "t4_clr_wins", 4'd9, 4'd9, 1'b0, 1'b0, 1'b0);
    expect_st(5, "t4_still_idle",4'd9, 4'd9, 1'b0, 1'b0, 1'b0);
    step(5);

    // 5: saturating preset in IDLE, load ignored in RUN
    preset_load = 1'b1; preset_val = 7'd7; step(1);
    expect_st(0, "t5_load7",    4'd0, 4'd7, 1'b0, 1'b0, 1'b0);
    preset_val = 7'd120; step(1); preset_load = 1'b0;
    expect_st(0, "t5_load120",  4'd9, 4'd9, 1'b0, 1'b0, 1'b0);
    btn_ss = 1'b1; step(1); btn_ss = 1'b0;
    expect_st(0,   "t5_run",       4'd9, 4'd9, 1'b1, 1'b0, 1'b0);
    expect_st(4,   "t5_load_ign",  4'd9, 4'd8, 1'b1, 1'b0, 1'b1);
    expect_st(228, "t5_at42",      4'd4, 4'd2, 1'b1, 1'b0, 1'b1);
    step(2);
    preset_load = 1'b1; preset_val = 7'd10; step(1); preset_load = 1'b0;
    step(226);

    // 6: asynchronous reset at 42 with start/stop held through release
    rst = 1'b0; btn_ss = 1'b1;
    expect_st(0, "t6_async_rst", 4'd9, 4'd9, 1'b0, 1'b0, 1'b0);
    step(2);
    rst = 1'b1;
    expect_st(5, "t6_no_start", 4'd9, 4'd9, 1'b0, 1'b0, 1'b0);
    step(5);
    btn_ss = 1'b0; step(1);
    btn_ss = 1'b1; step(1); btn_ss = 1'b0;
    expect_st(0, "t6_restart",  4'd9, 4'd9, 1'b1, 1'b0, 1'b0);
    expect_st(4, "t6_dec98",    4'd9, 4'd8, 1'b1, 1'b0, 1'b1);
    step(4);

    // 7: zero preset goes straight to DONE; start/stop leaves DONE at once
    btn_clr = 1'b1; step(1); btn_clr = 1'b0;
    expect_st(0, "t7_clear",    4'd9, 4'd9, 1'b0, 1'b0, 1'b0);
    preset_load = 1'b1; preset_val = 7'd0; step(1); preset_load = 1'b0;
    expect_st(0, "t7_load0",    4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    btn_ss = 1'b1; step(1); btn_ss = 1'b0;
    expect_st(0, "t7_direct_done", 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    step(1);
    btn_ss = 1'b1; step(1); btn_ss = 1'b0;
    expect_st(0, "t7_done_exit", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    expect_st(4, "t7_idle_hold", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    step(5);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain: %0d checks left pending, want 0", sb.size());
    end
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
